// File: rtl/alu_seq_ctrl.sv
// Command sequencer for a shared combinational ALU: single-cycle ops, a 32-step
// shift-add multiply, and a registered response channel with valid/ready handshakes.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_res,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_res,
  output logic        rsp_z,
  output logic        rsp_c,
  output logic        rsp_v,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  state_t      state, state_next;
  logic [2:0]  op_q;
  logic [31:0] a_q;      // operand A; shifted left as the multiplicand during MUL
  logic [31:0] b_q;      // operand B; shifted right as the multiplier during MUL
  logic [31:0] acc_q;
  logic [4:0]  cnt_q;
  logic [31:0] acc_next;
  logic        accept;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output is defaulted first so no path through the case leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    alu_opA    = '0;
    alu_opB    = '0;
    alu_sel    = OP_ADD;
    acc_next   = b_q[0] ? alu_res : acc_q;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept = 1'b1;
          case (req_op)
            OP_MUL:  state_next = S_MUL;
            OP_ILL:  state_next = S_RESP;
            default: state_next = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        alu_opA    = a_q;
        alu_opB    = b_q;
        alu_sel    = (op_q == OP_CMP) ? OP_SUB : op_q;
        state_next = S_RESP;
      end
      S_MUL: begin
        alu_opA = acc_q;
        alu_opB = a_q;
        alu_sel = OP_ADD;
        if (cnt_q == 5'd31) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: all datapath registers are plain flops (no memory arrays), so each is
  // cleared by the asynchronous reset to give a fully defined post-reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rsp_res <= '0;
      rsp_z   <= 1'b0;
      rsp_c   <= 1'b0;
      rsp_v   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            acc_q <= '0;
            cnt_q <= '0;
            // Illegal ops skip execution, so their response is loaded here.
            if (req_op == OP_ILL) begin
              rsp_res <= '0;
              rsp_z   <= 1'b0;
              rsp_c   <= 1'b0;
              rsp_v   <= 1'b0;
              rsp_err <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          rsp_res <= (op_q == OP_CMP) ? '0 : alu_res;
          rsp_z   <= alu_z;
          rsp_c   <= alu_c;
          rsp_v   <= alu_v;
          rsp_err <= 1'b0;
        end
        S_MUL: begin
          acc_q <= acc_next;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            rsp_res <= acc_next;
            rsp_z   <= (acc_next == '0);
            rsp_c   <= 1'b0;
            rsp_v   <= 1'b0;
            rsp_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: models the shared ALU, predicts each
// response into a scoreboard queue and compares when the DUT answers.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_opA, alu_opB;
  logic [2:0]  alu_sel;
  logic [31:0] alu_res;
  logic        alu_z, alu_c, alu_v;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_z, rsp_c, rsp_v, rsp_err;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        z, c, v, err;
    int          lat;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Shared combinational ALU; carry on SUB means "no borrow".
  logic [32:0] alu_w;
  always_comb begin
    alu_w = '0;
    alu_v = 1'b0;
    case (alu_sel)
      3'd0: begin
        alu_w = {1'b0, alu_opA} + {1'b0, alu_opB};
        alu_v = (alu_opA[31] == alu_opB[31]) && (alu_w[31] != alu_opA[31]);
      end
      3'd1: begin
        alu_w = {1'b0, alu_opA} + {1'b0, ~alu_opB} + 33'd1;
        alu_v = (alu_opA[31] != alu_opB[31]) && (alu_w[31] != alu_opA[31]);
      end
      3'd2:    alu_w = {1'b0, alu_opA & alu_opB};
      3'd3:    alu_w = {1'b0, alu_opA | alu_opB};
      3'd4:    alu_w = {1'b0, ~alu_opA};
      default: alu_w = '0;
    endcase
    alu_res = alu_w[31:0];
    alu_c   = alu_w[32];
    alu_z   = (alu_w[31:0] == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic rsp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rsp_t        r;
    logic [32:0] s;
    r.res = '0; r.z = 1'b0; r.c = 1'b0; r.v = 1'b0; r.err = 1'b0; r.lat = 2;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[31:0]; r.c = s[32];
        r.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'd1, 3'd5: begin
        s = {1'b0, a} - {1'b0, b};
        r.res = s[31:0]; r.c = (a >= b);
        r.v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      3'd2: r.res = a & b;
      3'd3: r.res = a | b;
      3'd4: r.res = ~a;
      3'd6: begin r.res = a * b; r.lat = 33; end
      default: begin r.err = 1'b1; r.lat = 1; end
    endcase
    r.z = (r.res == 32'd0) && !r.err;
    if (op == 3'd5) r.res = '0;
    return r;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int n = 0;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) sb_q.push_back(model(op, a, b));
    check("busy_after_accept", busy, 1);
  endtask

  task automatic collect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    int          n = 0;
    rsp_t        e;
    logic [31:0] held;
    @(negedge clk);
    if (op == 3'd7) begin
      check("ill_alu_opA", alu_opA, 0);
      check("ill_alu_opB", alu_opB, 0);
      check("ill_alu_sel", alu_sel, 0);
    end else if (op == 3'd6) begin
      check("mul_alu_sel", alu_sel, 0);
      check("mul_alu_opA", alu_opA, 0);
      check("mul_alu_opB", alu_opB, a);
    end else begin
      check("exec_alu_sel", alu_sel, (op == 3'd5) ? 32'd1 : 32'(op));
      check("exec_alu_opA", alu_opA, a);
      check("exec_alu_opB", alu_opB, b);
    end
    while (!rsp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rsp_valid", rsp_valid, 1);
    check("sb_nonempty", (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("latency", n + 1, e.lat);
      check("rsp_res", rsp_res, e.res);
      check("rsp_flags_zcv_err", {rsp_z, rsp_c, rsp_v, rsp_err}, {e.z, e.c, e.v, e.err});
    end
    check("resp_alu_quiet", alu_opA | alu_opB | 32'(alu_sel), 0);
    check("resp_req_ready", req_ready, 0);
    if (hold > 0) begin
      held = rsp_res;
      repeat (hold) begin
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd100; req_b = 32'd200;
        @(negedge clk);
        check("hold_rsp_res", rsp_res, held);
        check("hold_rsp_valid", rsp_valid, 1);
        check("hold_req_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("idle_after_resp_busy", busy, 0);
    check("idle_after_resp_valid", rsp_valid, 0);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1'b1);
    collect(op, a, b, 0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    bit          seen;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0;
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_res", rsp_res, 0);
    check("rst_rsp_flags", {rsp_z, rsp_c, rsp_v, rsp_err}, 0);
    check("rst_alu", alu_opA | alu_opB | 32'(alu_sel), 0);
    @(negedge clk);
    rst = 1'b0;

    run(3'd0, 32'hFFFF_FFFF, 32'h1);
    run(3'd5, 32'd5, 32'd5);
    run(3'd1, 32'd3, 32'd5);
    run(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
    run(3'd3, 32'hF000_0000, 32'h0000_000F);
    run(3'd4, 32'h1234_5678, 32'h0);
    run(3'd0, 32'h7FFF_FFFF, 32'h1);
    run(3'd6, 32'h0001_0001, 32'h3);
    run(3'd6, 32'd7, 32'd0);
    run(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd7, 32'hDEAD_BEEF, 32'h1);

    // Backpressure: response must hold while new requests are ignored.
    rsp_ready = 1'b0;
    issue(3'd0, 32'd2, 32'd3, 1'b1);
    collect(3'd0, 32'd2, 32'd3, 5);
    repeat (3) @(negedge clk);
    check("no_queued_cmd_busy", busy, 0);
    check("no_queued_cmd_rsp", rsp_valid, 0);

    repeat (12) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      run(r_op, r_a, r_b);
    end

    // Abort a multiply at step 10.
    issue(3'd6, 32'h1234, 32'h5678, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_alu", alu_opA | alu_opB | 32'(alu_sel), 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_rsp_res", rsp_res, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_response", seen, 0);

    run(3'd1, 32'd10, 32'd3);

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports req_valid input 1, req_ready output 1: command handshake; transfer when both high on a clk edge.
REQ-004 SHALL have ports req_op input 3, req_a input 32, req_b input 32: command opcode and operands.
REQ-005 SHALL have ports alu_opA output 32, alu_opB output 32, alu_sel output 3: drive the shared combinational ALU.
REQ-006 SHALL have ports alu_res input 32, alu_z, alu_c, alu_v input 1 each: ALU result and flags, same cycle as drive.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-008 SHALL have ports rsp_res output 32, rsp_z, rsp_c, rsp_v, rsp_err output 1 each: registered response payload.
REQ-009 SHALL have port busy output 1: high in every state except IDLE.

Function
REQ-010 SHALL decode req_op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT(A), 101 CMP, 110 MUL, 111 illegal.
REQ-011 SHALL implement FSM states IDLE, EXEC, MUL, RESP.
REQ-012 SHALL assert req_ready only in IDLE; command captured into internal op/A/B registers on accept.
REQ-013 IDLE->EXEC on accept of ops 000-101; IDLE->MUL on 110; IDLE->RESP on 111.
REQ-014 In EXEC SHALL drive alu_opA=A, alu_opB=B, alu_sel=op (CMP drives 001); register alu_res and flags; next state RESP.
REQ-015 CMP SHALL return rsp_res=0 with rsp_z/c/v equal to the ALU SUB flags.
REQ-016 MUL SHALL compute low 32 bits of A*B by exactly 32 shift-add steps, each using the ALU with alu_sel=000.
REQ-017 MUL step k (k=0..31): alu_opA=acc, alu_opB=mcand; if mplier[0]=1 acc<=alu_res else acc unchanged; mcand<=mcand<<1; mplier<=mplier>>1.
REQ-018 MUL init on accept: acc=0, mcand=A, mplier=B; 5-bit step counter 0..31; after step 31 next state RESP.
REQ-019 MUL response: rsp_res=acc, rsp_z=(acc==0), rsp_c=0, rsp_v=0.
REQ-020 Illegal op SHALL respond rsp_err=1, rsp_res=0, rsp_z=rsp_c=rsp_v=0; all legal ops respond rsp_err=0.
REQ-021 Outside EXEC/MUL, alu_opA, alu_opB SHALL be 0 and alu_sel 000.
REQ-022 rsp_valid SHALL be high exactly in RESP; payload stable while rsp_valid=1 and rsp_ready=0.
REQ-023 RESP->IDLE on rsp_ready=1; new command accepted no earlier than the cycle after.
REQ-024 Latency (accept edge T): ops 000-101 rsp_valid from T+2; illegal from T+1; MUL from T+33.
REQ-025 req_valid changes while busy SHALL have no effect; no command queued.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, req_ready=1, busy=0, rsp_valid=0, all rsp_* payload 0, alu_* outputs 0, internal registers 0.
REQ-027 rst asserted mid-EXEC, MUL or RESP SHALL abort the operation; no response is produced for it.
REQ-028 After rst deasserts, first command SHALL be accepted on the first clk edge with req_valid=1.

Verification
REQ-029 ADD A=FFFFFFFF, B=00000001, rsp_ready=1 -> rsp_valid at T+2, rsp_res=0, z=1, c=1, v=0, err=0.
REQ-030 CMP A=5, B=5 -> rsp_res=0, z=1, c=1, v=0; ALU saw alu_sel=001 in EXEC cycle.
REQ-031 MUL A=00010001, B=00000003 -> rsp_valid at T+33, rsp_res=00030003, z=0; MUL A=7, B=0 -> rsp_res=0, z=1.
REQ-032 Op 111 -> rsp_valid at T+1, rsp_err=1, rsp_res=0; ALU outputs stay 0.
REQ-033 Hold rsp_ready=0 for 5 cycles after ADD 2+3 -> rsp_res=5 stable, req_ready=0, second req_valid ignored; release -> IDLE next cycle.
REQ-034 Assert rst at MUL step 10 -> same cycle busy=0, rsp_valid=0, alu_* =0; no response after release.
